load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads with extension, sub-word stores via read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN reports misaligned requests through resp_err instead of aligning them.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [1:0]  op_off;
    logic [31:0] op_wdata;
    logic        op_trap;
    logic        req_trap;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_trap = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign req_trap = 1'b0;
`endif

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extract = {{24{sgn & b[7]}}, b};
            2'b01:   load_extract = {{16{sgn & h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    // Replace only the addressed lane(s) of the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] w;
        w = word;
        case (size)
            2'b00: w[{off, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (off[1]) w[31:16] = wdata[15:0];
                else        w[15:0]  = wdata[15:0];
            end
            default: w = wdata;
        endcase
        store_merge = w;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_err       <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= 32'd0;
            op_size        <= 2'b00;
            op_signed      <= 1'b0;
            op_off         <= 2'b00;
            op_wdata       <= 32'd0;
            op_trap        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        op_size     <= req_size;
                        op_signed   <= req_signed;
                        op_off      <= req_addr[1:0];
                        op_wdata    <= req_wdata;
                        op_trap     <= req_trap;
                        mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_trap) begin
                            // Trapped requests take a dead cycle so their response latency matches a load.
                            state <= LOAD;
                        end else if (!req_write) begin
                            state    <= LOAD;
                            mem_read <= 1'b1;
                        end else if (req_size[1]) begin
                            state          <= STORE;
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            state    <= RMW_RD;
                            mem_read <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state      <= RESP;
                    mem_read   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= op_trap;
                    resp_rdata <= op_trap ? 32'd0
                                          : load_extract(mem_read_data, op_size, op_signed, op_off);
                end
                RMW_RD: begin
                    state          <= STORE;
                    mem_read       <= 1'b0;
                    mem_write      <= 1'b1;
                    mem_write_data <= store_merge(mem_read_data, op_wdata, op_size, op_off);
                end
                STORE: begin
                    state      <= RESP;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random traffic against a
// word-array reference model, and reset in the middle of a read-modify-write.
module tb_load_store_unit;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    // Data memory: combinational read, write on the clock edge.
    logic [31:0] mem [0:63];
    logic        mem_init;
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_write) begin
            mem[mem_address[7:2]] <= mem_write_data;
        end
    end

    int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, excl_err = 0, align_err = 0;
    always @(posedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (resp_valid) resp_cnt++;
        if (mem_read && mem_write) excl_err++;
        if ((mem_read || mem_write) && mem_address[1:0] != 2'b00) align_err++;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_mem [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: memory as a word array, lanes computed arithmetically from byte count and offset.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int nrd, output int nwr);
        int     nb, off, idx;
        longint mask, word, v;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        idx = int'(a[7:2]);
        off = (int'(a[1:0]) / nb) * nb;
        er  = 1'b0;
        rd  = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (int'(a[1:0]) % nb != 0) begin
            er = 1'b1; lat = 2; nrd = 0; nwr = 0;
            return;
        end
`endif
        mask = (longint'(1) << (8 * nb)) - 1;
        word = longint'(ref_mem[idx]);
        if (!w) begin
            v = (word >> (8 * off)) & mask;
            if (sg && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~mask;
            rd  = v[31:0];
            lat = 2; nrd = 1; nwr = 0;
        end else begin
            word = (word & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
            ref_mem[idx] = word[31:0];
            lat = (nb == 4) ? 2 : 3;
            nrd = (nb == 4) ? 0 : 1;
            nwr = 1;
        end
    endtask

    task automatic exercise(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat, e_nrd, e_nwr, r0, w0, lat, g;
        got = 32'hxxxxxxxx;
        model(w, sz, sg, a, wd, e_rd, e_err, e_lat, e_nrd, e_nwr);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: req_ready stuck at %b, expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        r0 = rd_cnt; w0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) begin
            vectors++; miscompares++;
            $display("FAIL resp_timeout: resp_valid %b after %0d cycles, expected 1", resp_valid, lat);
            return;
        end
        got = resp_rdata;
        check("rdata", resp_rdata, e_rd);
        check("err", 32'(resp_err), 32'(e_err));
        check("latency", 32'(lat), 32'(e_lat));
        check("mem_read_cycles", 32'(rd_cnt - r0), 32'(e_nrd));
        check("mem_write_cycles", 32'(wr_cnt - w0), 32'(e_nwr));
        check("mem_word", mem[a[7:2]], ref_mem[a[7:2]]);
        @(posedge clk);
        #1;
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
        check("ready_after_resp", 32'(req_ready), 32'd1);
        check("rdata_held", resp_rdata, got);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
        vec_t v;
        v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd; v.exp = exp;
        return v;
    endfunction

    vec_t        vt [16];
    logic [31:0] got;
    int          w0, p0;

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        vt[0]  = mk(1'b1, 2'b10, 1'b0, 32'hA4, 32'hDEADBEEF, 32'h00000000);
        vt[1]  = mk(1'b0, 2'b10, 1'b0, 32'hA4, 32'h0,        32'hDEADBEEF);
        vt[2]  = mk(1'b1, 2'b10, 1'b0, 32'hA4, 32'h80FF7F01, 32'h00000000);
        vt[3]  = mk(1'b0, 2'b00, 1'b1, 32'hA6, 32'h0,        32'hFFFFFFFF);
        vt[4]  = mk(1'b0, 2'b00, 1'b0, 32'hA6, 32'h0,        32'h000000FF);
        vt[5]  = mk(1'b0, 2'b00, 1'b1, 32'hA4, 32'h0,        32'h00000001);
        vt[6]  = mk(1'b0, 2'b01, 1'b1, 32'hA6, 32'h0,        32'hFFFF80FF);
        vt[7]  = mk(1'b1, 2'b10, 1'b0, 32'hA4, 32'h11223344, 32'h00000000);
        vt[8]  = mk(1'b1, 2'b01, 1'b0, 32'hA6, 32'h0000ABCD, 32'h00000000);
        vt[9]  = mk(1'b0, 2'b10, 1'b0, 32'hA4, 32'h0,        32'hABCD3344);
`ifdef LSU_MISALIGN_TRAP_EN
        vt[10] = mk(1'b0, 2'b10, 1'b0, 32'hA5, 32'h0,        32'h00000000);
`else
        vt[10] = mk(1'b0, 2'b10, 1'b0, 32'hA5, 32'h0,        32'hABCD3344);
`endif
        vt[11] = mk(1'b0, 2'b11, 1'b0, 32'hA4, 32'h0,        32'hABCD3344);
        vt[12] = mk(1'b0, 2'b00, 1'b0, 32'hA7, 32'h0,        32'h000000AB);
        vt[13] = mk(1'b1, 2'b00, 1'b0, 32'hA5, 32'h12345677, 32'h00000000);
        vt[14] = mk(1'b0, 2'b10, 1'b0, 32'hA4, 32'h0,        32'hABCD7744);
        vt[15] = mk(1'b0, 2'b01, 1'b0, 32'hA4, 32'h0,        32'h00007744);

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_write_data", mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;

        for (int i = 0; i < 16; i++) begin
            exercise(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, got);
            check($sformatf("table_%0d", i), got, vt[i].exp);
        end

        for (int i = 0; i < 150; i++) begin
            exercise(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 255)), $urandom, got);
        end

        // Reset while a byte store sits in its read phase.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'hA4; req_wdata = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rmw_rd_mem_read", 32'(mem_read), 32'd1);
        w0 = wr_cnt; p0 = resp_cnt;
        reset = 1'b1;
        #1;
        check("midreset_req_ready", 32'(req_ready), 32'd1);
        check("midreset_mem_read", 32'(mem_read), 32'd0);
        check("midreset_mem_write", 32'(mem_write), 32'd0);
        check("midreset_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("dropped_no_write", 32'(wr_cnt - w0), 32'd0);
        check("dropped_no_resp", 32'(resp_cnt - p0), 32'd0);
        check("dropped_mem_unchanged", mem[6'h29], ref_mem[6'h29]);
        exercise(1'b0, 2'b10, 1'b0, 32'hA4, 32'h0, got);

        check("rw_exclusive", 32'(excl_err), 32'd0);
        check("addr_word_aligned", 32'(align_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
